// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared FSM state type and counter sizing for the serial transmitter
package piso_tx_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_shift_reg_load.sv
// shift_reg_load: loadable shift register that presents the outgoing bit and fills with zeros
module shift_reg_load #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_q;

    // zero fill empties the register by the end of a frame, so the idle line reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_load)
            r_q <= i_din;
        else if (i_shift)
            r_q <= MSB_FIRST ? {r_q[WIDTH-2:0], 1'b0} : {1'b0, r_q[WIDTH-1:1]};
    end

    assign o_bit = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: rtl/piso_tx.sv
// piso_tx: valid/ready word intake, shifted out one bit per clock with start/end strobes
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_valid, r_start, r_end;
    logic          w_last, w_accept;

    always_comb begin
        w_last      = (r_state == SHIFT) && (r_cnt == LAST);
        din_ready   = (r_state == IDLE) || w_last;
        w_accept    = din_valid && din_ready;
        w_state_nxt = w_accept ? SHIFT : (w_last ? IDLE : r_state);
        w_cnt_nxt   = (w_accept || w_last) ? '0 : ((r_state == SHIFT) ? r_cnt + 1'b1 : r_cnt);
    end

    // strobes are computed from the next state so they line up with the bit they frame
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_state_nxt == SHIFT);
            r_start <= w_accept;
            r_end   <= (w_state_nxt == SHIFT) && (w_cnt_nxt == LAST);
        end
    end

    shift_reg_load #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sr (
        .clk    (clk),
        .rst_n  (async_reset_n),
        .i_load (w_accept),
        .i_shift(r_state == SHIFT),
        .i_din  (din),
        .o_bit  (sout)
    );

    assign sout_valid  = r_valid;
    assign frame_start = r_start;
    assign frame_end   = r_end;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: MSB-first and LSB-first transmitters driven in lockstep, checked per cycle against a bit queue model
module tb_piso_tx;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         din_valid = 1'b0;
    logic [W-1:0] din       = '0;
    logic         m_ready, m_sout, m_valid, m_start, m_end;
    logic         l_ready, l_sout, l_valid, l_start, l_end;
    logic [9:0]   obs;

    typedef struct {
        logic [W-1:0] w;
        int           i;
    } bit_t;

    bit_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic last_acc = 1'b0;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .async_reset_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(m_ready),
        .sout(m_sout), .sout_valid(m_valid), .frame_start(m_start), .frame_end(m_end)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .async_reset_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(l_ready),
        .sout(l_sout), .sout_valid(l_valid), .frame_start(l_start), .frame_end(l_end)
    );

    always #5 clk = ~clk;

    assign obs = {m_sout, l_sout, m_valid, m_start, m_end, m_ready, l_valid, l_start, l_end, l_ready};

    // every accepted word becomes W queued bit slots; the head slot is what the line shows now
    function automatic logic [9:0] exp_vec();
        bit_t e;
        logic [3:0] f;
        if (q.size() == 0) return 10'b00_0001_0001;
        e = q[0];
        f = {1'b1, e.i == 0, e.i == W - 1, q.size() == 1};
        return {e.w[W-1-e.i], e.w[e.i], f, f};
    endfunction

    task automatic tick();
        logic         acc;
        logic [W-1:0] d;
        acc = rst_n && din_valid && (q.size() <= 1);
        d   = din;
        @(posedge clk);
        if (!rst_n) q.delete();
        else begin
            if (q.size() > 0) q.delete(0);
            if (acc) for (int i = 0; i < W; i++) q.push_back('{d, i});
        end
        last_acc = acc;
        #1;
    endtask

    task automatic test_reset();
        din_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 q.delete();
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_assert: got %b expected %b", obs, exp_vec()); end
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_hold: got %b expected %b", obs, exp_vec()); end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle c%0d: got %b expected %b", c, obs, exp_vec()); end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] mw = '0, lw = '0;
        din = 8'hA5;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din = 8'h00;
        for (int c = 0; c < 9; c++) begin
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL single c%0d: got %b expected %b", c, obs, exp_vec()); end
            if (m_valid) mw = {mw[W-2:0], m_sout};
            if (l_valid) lw = {l_sout, lw[W-1:1]};
            tick();
        end
        n_cmp++;
        if (mw !== 8'hA5) begin n_bad++; $display("FAIL single_msb_word: got %h expected a5", mw); end
        n_cmp++;
        if (lw !== 8'hA5) begin n_bad++; $display("FAIL single_lsb_word: got %h expected a5", lw); end
    endtask

    task automatic test_back_to_back();
        int na = 0, nv = 0, fv = -1, lv = -1;
        din = 8'hFF;
        din_valid = 1'b1;
        for (int c = 0; c < 19; c++) begin
            tick();
            na += int'(last_acc);
            if (na == 1) din = 8'h00;
            if (na == 2) din_valid = 1'b0;
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL b2b c%0d: got %b expected %b", c, obs, exp_vec()); end
            if (m_valid) begin nv++; lv = c; if (fv < 0) fv = c; end
        end
        n_cmp++;
        if (nv !== 16 || lv - fv !== 15) begin
            n_bad++; $display("FAIL b2b_contiguous: got %0d valid cycles spanning %0d expected 16 spanning 16", nv, lv - fv + 1);
        end
    endtask

    task automatic test_backpressure();
        int na = 0, ns = 0;
        logic [W-1:0] mw = '0;
        din = 8'h12;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin din = 8'h3C; din_valid = 1'b1; end
            if (c == 4) din = 8'hC3;
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL bp c%0d: got %b expected %b", c, obs, exp_vec()); end
            ns += int'(m_start);
            if (ns == 2 && m_valid) mw = {mw[W-2:0], m_sout};
            tick();
            na += int'(last_acc);
            if (na == 1) din_valid = 1'b0;
        end
        n_cmp++;
        if (mw !== 8'hC3) begin n_bad++; $display("FAIL bp_word: got %h expected c3", mw); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            if (!din_valid || last_acc) din_valid = ($urandom_range(0, 3) != 0);
            din = W'($urandom);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL random c%0d: got %b expected %b", c, obs, exp_vec()); end
        end
        din_valid = 1'b0;
        for (int c = 0; c < W + 1; c++) tick();
    endtask

    task automatic test_reset_mid();
        din = 8'h5A;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL mid_pre c%0d: got %b expected %b", c, obs, exp_vec()); end
            tick();
        end
        n_cmp++;
        if (obs !== exp_vec() || !m_valid) begin n_bad++; $display("FAIL mid_bit4: got %b expected %b", obs, exp_vec()); end
        #2 rst_n = 1'b0;
        #1 q.delete();
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL mid_reset_async: got %b expected %b", obs, exp_vec()); end
        tick();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL mid_post c%0d: got %b expected %b", c, obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
